universal_shift_register: RTL and testbench

Parametrised universal shift register for serial/parallel conversion in the training datapaths.
- Supports hold, logical and arithmetic shifts, rotates, parallel load and clear, selected by a mode code and qualified by an enable.
- Serial inputs and outputs at both ends; a shift counter tracks progress since the last load and flags when a full word has been shifted out.

---
 rtl/universal_shift_register.sv | 103 ++++++++++
 tb/tb_universal_shift_register.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, logical/arithmetic shifts, rotates, load and clear,
// with a saturating shift counter that flags when a full word has been shifted out.
module universal_shift_register #(
    parameter int BW_DATA = 8,
    parameter int BW_CNT  = $clog2(BW_DATA + 1)
) (
    input  logic               i_Clk,
    input  logic               i_Rstn,
    input  logic               i_En,
    input  logic [2:0]         i_Mode,
    input  logic [BW_DATA-1:0] i_D,
    input  logic               i_SinR,
    input  logic               i_SinL,
    output logic [BW_DATA-1:0] o_Qout,
    output logic               o_SoutL,
    output logic               o_SoutR,
    output logic [BW_CNT-1:0]  o_Cnt,
    output logic               o_Done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    localparam logic [BW_CNT-1:0] CNT_MAX = BW_CNT'(BW_DATA);

    function automatic logic [BW_CNT-1:0] sat_inc(input logic [BW_CNT-1:0] cnt);
        if (cnt >= CNT_MAX)
            return CNT_MAX;
        else
            return cnt + BW_CNT'(1);
    endfunction

    logic        [BW_DATA-1:0] q_p0;
    logic        [BW_CNT-1:0]  cnt_p0;
    logic        [BW_DATA-1:0] q_nxt;
    logic        [BW_CNT-1:0]  cnt_nxt;
    logic signed [BW_DATA-1:0] q_signed;
    logic signed [BW_DATA-1:0] q_asr;

    assign q_signed = q_p0;
    assign q_asr    = q_signed >>> 1;

    always_comb begin
        q_nxt   = q_p0;
        cnt_nxt = cnt_p0;
        unique case (i_Mode)
            MODE_HOLD: ;
            MODE_SHL: begin
                q_nxt   = {q_p0[BW_DATA-2:0], i_SinR};
                cnt_nxt = sat_inc(cnt_p0);
            end
            MODE_SHR: begin
                q_nxt   = {i_SinL, q_p0[BW_DATA-1:1]};
                cnt_nxt = sat_inc(cnt_p0);
            end
            MODE_ROL: begin
                q_nxt   = {q_p0[BW_DATA-2:0], q_p0[BW_DATA-1]};
                cnt_nxt = sat_inc(cnt_p0);
            end
            MODE_ROR: begin
                q_nxt   = {q_p0[0], q_p0[BW_DATA-1:1]};
                cnt_nxt = sat_inc(cnt_p0);
            end
            MODE_LOAD: begin
                q_nxt   = i_D;
                cnt_nxt = '0;
            end
            MODE_ASR: begin
                q_nxt   = q_asr;
                cnt_nxt = sat_inc(cnt_p0);
            end
            MODE_CLR: begin
                q_nxt   = '0;
                cnt_nxt = '0;
            end
            default: ;
        endcase
    end

    // Register stage: reset dominates enable and mode
    always_ff @(posedge i_Clk) begin
        if (!i_Rstn) begin
            q_p0   <= '0;
            cnt_p0 <= '0;
        end else if (i_En) begin
            q_p0   <= q_nxt;
            cnt_p0 <= cnt_nxt;
        end
    end

    assign o_Qout  = q_p0;
    assign o_SoutL = q_p0[BW_DATA-1];
    assign o_SoutR = q_p0[0];
    assign o_Cnt   = cnt_p0;
    assign o_Done  = (cnt_p0 == CNT_MAX);

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed table-driven bench for universal_shift_register (8-bit instance)
// plus a hand-written sequence on a 16-bit instance.
module tb_universal_shift_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit DUT
    logic       rstn8, en8, sinr8, sinl8;
    logic [2:0] mode8;
    logic [7:0] d8, q8;
    logic       soutl8, soutr8, done8;
    logic [3:0] cnt8;

    universal_shift_register #(.BW_DATA(8)) dut8 (
        .i_Clk(clk), .i_Rstn(rstn8), .i_En(en8), .i_Mode(mode8), .i_D(d8),
        .i_SinR(sinr8), .i_SinL(sinl8), .o_Qout(q8), .o_SoutL(soutl8),
        .o_SoutR(soutr8), .o_Cnt(cnt8), .o_Done(done8)
    );

    // 16-bit DUT
    logic        rstn16, en16, sinr16, sinl16;
    logic [2:0]  mode16;
    logic [15:0] d16, q16;
    logic        soutl16, soutr16, done16;
    logic [4:0]  cnt16;

    universal_shift_register #(.BW_DATA(16)) dut16 (
        .i_Clk(clk), .i_Rstn(rstn16), .i_En(en16), .i_Mode(mode16), .i_D(d16),
        .i_SinR(sinr16), .i_SinL(sinl16), .o_Qout(q16), .o_SoutL(soutl16),
        .o_SoutR(soutr16), .o_Cnt(cnt16), .o_Done(done16)
    );

    typedef struct {
        logic       rstn;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sinr;
        logic       sinl;
        logic [7:0] exp_q;
        logic [3:0] exp_cnt;
    } vec_t;

    localparam int MAXV = 96;
    vec_t vecs[MAXV];
    int   nvec = 0;
    int   total = 0;
    int   bad = 0;

    task automatic add(input logic rstn, input logic en, input logic [2:0] mode,
                       input logic [7:0] d, input logic sinr, input logic sinl,
                       input logic [7:0] exp_q, input logic [3:0] exp_cnt);
        vecs[nvec].rstn    = rstn;
        vecs[nvec].en      = en;
        vecs[nvec].mode    = mode;
        vecs[nvec].d       = d;
        vecs[nvec].sinr    = sinr;
        vecs[nvec].sinl    = sinl;
        vecs[nvec].exp_q   = exp_q;
        vecs[nvec].exp_cnt = exp_cnt;
        nvec++;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    initial begin
        // mode shorthand: 0 HOLD 1 SHL 2 SHR 3 ROL 4 ROR 5 LOAD 6 ASR 7 CLR
        // Reset with LOAD of FF pending
        add(0, 1, 5, 8'hFF, 0, 0, 8'h00, 0);
        add(0, 1, 5, 8'hFF, 0, 0, 8'h00, 0);
        // LOAD A5 then 9 SHL with SinR=0, then one with SinR=1
        add(1, 1, 5, 8'hA5, 0, 0, 8'hA5, 0);
        add(1, 1, 1, 8'h00, 0, 0, 8'h4A, 1);
        add(1, 1, 1, 8'h00, 0, 0, 8'h94, 2);
        add(1, 1, 1, 8'h00, 0, 0, 8'h28, 3);
        add(1, 1, 1, 8'h00, 0, 0, 8'h50, 4);
        add(1, 1, 1, 8'h00, 0, 0, 8'hA0, 5);
        add(1, 1, 1, 8'h00, 0, 0, 8'h40, 6);
        add(1, 1, 1, 8'h00, 0, 0, 8'h80, 7);
        add(1, 1, 1, 8'h00, 0, 0, 8'h00, 8);
        add(1, 1, 1, 8'h00, 0, 0, 8'h00, 8);
        add(1, 1, 1, 8'h00, 1, 0, 8'h01, 8);
        // Rotates and shifts from loads
        add(1, 1, 5, 8'h81, 0, 0, 8'h81, 0);
        add(1, 1, 4, 8'h00, 1, 1, 8'hC0, 1);
        add(1, 1, 5, 8'h81, 0, 0, 8'h81, 0);
        add(1, 1, 3, 8'h00, 0, 0, 8'h03, 1);
        add(1, 1, 5, 8'h90, 0, 0, 8'h90, 0);
        add(1, 1, 2, 8'h00, 0, 1, 8'hC8, 1);
        add(1, 1, 5, 8'h90, 0, 0, 8'h90, 0);
        add(1, 1, 6, 8'h00, 0, 0, 8'hC8, 1);
        add(1, 1, 6, 8'h00, 0, 0, 8'hE4, 2);
        add(1, 1, 2, 8'h00, 1, 0, 8'h72, 3);
        add(1, 1, 5, 8'h40, 0, 0, 8'h40, 0);
        add(1, 1, 6, 8'h00, 0, 1, 8'h20, 1);
        // Enable gating
        add(1, 1, 5, 8'h3C, 0, 0, 8'h3C, 0);
        add(1, 0, 7, 8'h00, 0, 0, 8'h3C, 0);
        add(1, 0, 7, 8'h00, 0, 0, 8'h3C, 0);
        add(1, 0, 7, 8'h00, 0, 0, 8'h3C, 0);
        add(1, 1, 0, 8'hFF, 1, 1, 8'h3C, 0);
        add(1, 1, 1, 8'h00, 1, 0, 8'h79, 1);
        add(1, 0, 1, 8'h00, 1, 0, 8'h79, 1);
        add(1, 1, 0, 8'h00, 1, 1, 8'h79, 1);
        add(1, 1, 7, 8'hFF, 1, 1, 8'h00, 0);
        // Reset mid-sequence, then resume
        add(1, 1, 5, 8'hF0, 0, 0, 8'hF0, 0);
        add(1, 1, 1, 8'h00, 0, 0, 8'hE0, 1);
        add(1, 1, 1, 8'h00, 0, 0, 8'hC0, 2);
        add(1, 1, 1, 8'h00, 0, 0, 8'h80, 3);
        add(0, 1, 1, 8'h00, 1, 0, 8'h00, 0);
        add(1, 1, 1, 8'h00, 1, 0, 8'h01, 1);
        add(0, 0, 5, 8'hAA, 0, 0, 8'h00, 0);
        // Saturate with ROL, then LOAD
        add(1, 1, 5, 8'h55, 0, 0, 8'h55, 0);
        add(1, 1, 3, 8'h00, 0, 0, 8'hAA, 1);
        add(1, 1, 3, 8'h00, 0, 0, 8'h55, 2);
        add(1, 1, 3, 8'h00, 0, 0, 8'hAA, 3);
        add(1, 1, 3, 8'h00, 0, 0, 8'h55, 4);
        add(1, 1, 3, 8'h00, 0, 0, 8'hAA, 5);
        add(1, 1, 3, 8'h00, 0, 0, 8'h55, 6);
        add(1, 1, 3, 8'h00, 0, 0, 8'hAA, 7);
        add(1, 1, 3, 8'h00, 0, 0, 8'h55, 8);
        add(1, 1, 4, 8'h00, 0, 0, 8'hAA, 8);
        add(1, 1, 0, 8'h00, 0, 0, 8'hAA, 8);
        add(1, 1, 5, 8'h55, 0, 0, 8'h55, 0);

        rstn8 = 1'b0; en8 = 1'b0; mode8 = 3'd0; d8 = '0; sinr8 = 1'b0; sinl8 = 1'b0;
        rstn16 = 1'b0; en16 = 1'b1; mode16 = 3'd0; d16 = '0; sinr16 = 1'b0; sinl16 = 1'b0;

        @(posedge clk); #1;
        for (int i = 0; i < nvec; i++) begin
            rstn8 = vecs[i].rstn;
            en8   = vecs[i].en;
            mode8 = vecs[i].mode;
            d8    = vecs[i].d;
            sinr8 = vecs[i].sinr;
            sinl8 = vecs[i].sinl;
            @(posedge clk); #1;
            check("q",     i, 32'(q8),     32'(vecs[i].exp_q));
            check("cnt",   i, 32'(cnt8),   32'(vecs[i].exp_cnt));
            check("done",  i, 32'(done8),  32'(vecs[i].exp_cnt == 4'd8));
            check("soutl", i, 32'(soutl8), 32'(vecs[i].exp_q[7]));
            check("soutr", i, 32'(soutr8), 32'(vecs[i].exp_q[0]));
        end

        // 16-bit instance: reset, LOAD 8001, ASR to saturation
        rstn16 = 1'b0; mode16 = 3'd5; d16 = 16'hFFFF;
        @(posedge clk); #1;
        check("w16_rst_q",   100, 32'(q16),   32'h0);
        check("w16_rst_cnt", 100, 32'(cnt16), 32'd0);
        rstn16 = 1'b1; mode16 = 3'd5; d16 = 16'h8001;
        @(posedge clk); #1;
        check("w16_load_q", 101, 32'(q16), 32'h8001);
        mode16 = 3'd6; sinl16 = 1'b0;
        @(posedge clk); #1;
        check("w16_asr_q",   102, 32'(q16),   32'hC000);
        check("w16_asr_cnt", 102, 32'(cnt16), 32'd1);
        for (int k = 2; k <= 17; k++) begin
            @(posedge clk); #1;
            if (k == 15) begin
                check("w16_cnt15",  103, 32'(cnt16),  32'd15);
                check("w16_done15", 103, 32'(done16), 32'd0);
            end
        end
        check("w16_sat_q",    104, 32'(q16),     32'hFFFF);
        check("w16_sat_cnt",  104, 32'(cnt16),   32'd16);
        check("w16_sat_done", 104, 32'(done16),  32'd1);
        check("w16_soutl",    104, 32'(soutl16), 32'd1);
        mode16 = 3'd5; d16 = 16'h1234;
        @(posedge clk); #1;
        check("w16_reload_q",    105, 32'(q16),    32'h1234);
        check("w16_reload_done", 105, 32'(done16), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
